// File: rtl/ysyx_22040759_ifu_pkg.sv
// Shared fetch-stage definitions: FSM encodings, reset PC and the next-PC
// select codes that decode drives on pc_sel.
package ysyx_22040759_ifu_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_ERR  = 2'd3
   } ifu_state_e;

   localparam logic PC_PC  = 1'b0;
   localparam logic PC_ALU = 1'b1;

   // Bit 0 of a jalr target is discarded, so only bit 1 can make it misaligned.
   function automatic logic target_misaligned(input logic sel, input logic bit1);
      return (sel == PC_ALU) && bit1;
   endfunction

endpackage

// File: rtl/ysyx_22040759_pc_next.sv
// Combinational next-PC selection with misaligned-jump detection.
module ysyx_22040759_pc_next
   import ysyx_22040759_ifu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              pc_sel,
   input  logic [ADDR_W-1:0] jmp_target,
   output logic [ADDR_W-1:0] next_pc,
   output logic              misalign
);

   always_comb begin
      next_pc  = pc + ADDR_W'(4);
      misalign = target_misaligned(pc_sel, jmp_target[1]);
      if (pc_sel == PC_ALU) begin
         next_pc = {jmp_target[ADDR_W-1:1], 1'b0};
      end
   end

endmodule

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// valid/ready handshake and holds it for decode until retired.
module ysyx_22040759_ifu
   import ysyx_22040759_ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              inst_valid_o,
   input  logic              id_ready,
   input  logic              pc_sel,
   input  logic [ADDR_W-1:0] jmp_target,
   output logic              fetch_err_o,
   output logic [63:0]       inst_cnt_o
);

   ifu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       inst_q;
   logic              err_q;
   logic [63:0]       cnt_q;
   logic [ADDR_W-1:0] next_pc;
   logic              misalign;
   logic              capture;
   logic              retire;

   ysyx_22040759_pc_next #(
      .ADDR_W(ADDR_W)
   ) u_pc_next (
      .pc        (pc_q),
      .pc_sel    (pc_sel),
      .jmp_target(jmp_target),
      .next_pc   (next_pc),
      .misalign  (misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   // A response is only taken in S_WAIT or alongside an accepted request.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      retire  = 1'b0;
      case (state_q)
         S_REQ: begin
            if (imem_req_ready) begin
               capture = imem_rsp_valid;
               state_d = imem_rsp_valid ? S_HOLD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (id_ready) begin
               retire  = 1'b1;
               state_d = misalign ? S_ERR : S_REQ;
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         inst_q <= 32'h0;
         err_q  <= 1'b0;
         cnt_q  <= 64'd0;
      end else begin
         if (capture) begin
            inst_q <= imem_rsp_data;
         end
         if (retire) begin
            cnt_q <= cnt_q + 64'd1;
            if (misalign) begin
               err_q <= 1'b1;
            end else begin
               pc_q <= next_pc;
            end
         end
      end
   end

   assign imem_req_valid = (state_q == S_REQ) && !rst;
   assign imem_req_addr  = pc_q;
   assign inst_o         = inst_q;
   assign pc_o           = pc_q;
   assign inst_valid_o   = (state_q == S_HOLD);
   assign fetch_err_o    = err_q;
   assign inst_cnt_o     = cnt_q;

endmodule
